spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI master: 10-bit command/payload frame out, optional 8-bit read-back in.
// Define SPI_MASTER_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module spi_master #(
  parameter int RD_WAIT  = 1,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SS_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
`ifdef SPI_MASTER_FRAME_CNT_EN
  output logic       rd_valid,
  output logic [15:0] frame_cnt
`else
  output logic       rd_valid
`endif
);

  typedef enum logic [2:0] {IDLE, SELECT, SHIFT_OUT, WAIT_RD, SHIFT_IN, GAP} state_t;

  state_t      state_q, state_d;
  logic [9:0]  frame_q, frame_d;
  logic        rd_q, rd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        mosi_q, mosi_d;
  logic        ss_n_q, ss_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_valid_q, rd_valid_d;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        frame_d = {cmd, din};
        rd_d    = (cmd == 2'b11);
        ss_n_d  = 1'b0;
        mosi_d  = cmd[1];
        busy_d  = 1'b1;
        state_d = SELECT;
      end
      SELECT: begin
        mosi_d  = frame_q[9];
        cnt_d   = 4'd10;
        state_d = SHIFT_OUT;
      end
      // cnt 10..1 present frame[9]..frame[0]; cnt 0 is a trailing low-MOSI
      // cycle that closes the command phase (12 SS_n-low cycles in total).
      SHIFT_OUT: begin
        mosi_d  = frame_q[8];
        frame_d = {frame_q[8:0], 1'b0};
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mosi_d = 1'b0;
          if (!rd_q) begin
            ss_n_d  = 1'b1;
            done_d  = 1'b1;
            cnt_d   = 4'(IDLE_GAP);
            state_d = GAP;
          end else if (RD_WAIT == 0) begin
            cnt_d   = 4'd8;
            state_d = SHIFT_IN;
          end else begin
            cnt_d   = 4'(RD_WAIT);
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd8;
          state_d = SHIFT_IN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SHIFT_IN: begin
        shift_d = {shift_q[6:0], MISO};
        if (cnt_q <= 4'd1) begin
          rd_data_d  = shift_d;
          ss_n_d     = 1'b1;
          done_d     = 1'b1;
          rd_valid_d = 1'b1;
          cnt_d      = 4'(IDLE_GAP);
          state_d    = GAP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cnt_q <= 4'd1) begin
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      rd_q       <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      rd_data_q  <= '0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef SPI_MASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  always_comb frame_cnt_d = done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end
  assign frame_cnt = frame_cnt_q;
`endif

  assign MOSI     = mosi_q;
  assign SS_n     = ss_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule
